// File: rtl/fp_mult.sv
// Three-stage IEEE-754 binary32 multiplier: unpack/classify, mantissa multiply,
// normalise/round/pack. Denormal inputs flush to zero; one canonical NaN.
module fp_mult (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] result
);

  // Zero is encoded as 0 so that cleared pipeline registers yield a +0 result.
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  localparam logic [31:0] CANON_NAN = 32'h7F80_0001;

  // ---------------- stage 1: unpack and classify ----------------
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  cls_e        cls_d;

  assign exp_a  = dataA[30:23];
  assign exp_b  = dataB[30:23];
  assign frac_a = dataA[22:0];
  assign frac_b = dataB[22:0];
  assign a_nan  = (&exp_a) & (|frac_a);
  assign b_nan  = (&exp_b) & (|frac_b);
  assign a_inf  = (&exp_a) & ~(|frac_a);
  assign b_inf  = (&exp_b) & ~(|frac_b);
  assign a_zero = ~(|exp_a);
  assign b_zero = ~(|exp_b);

  // NOTE: combinational blocks use blocking assignments and set every output
  // to a default first, so no path can leave a value held (no latch).
  always_comb begin
    cls_d = CLS_NORM;
    if (a_nan || b_nan)                          cls_d = CLS_NAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) cls_d = CLS_NAN;
    else if (a_inf || b_inf)                     cls_d = CLS_INF;
    else if (a_zero || b_zero)                   cls_d = CLS_ZERO;
  end

  logic               s1_sign;
  logic signed [9:0]  s1_exp;
  logic [23:0]        s1_mant_a, s1_mant_b;
  cls_e               s1_cls;

  // NOTE: sequential state uses non-blocking assignments only; the synchronous
  // reset clears every pipeline register so no stale operation can surface.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_mant_a <= '0;
      s1_mant_b <= '0;
      s1_cls    <= CLS_ZERO;
    end else begin
      s1_sign   <= dataA[31] ^ dataB[31];
      s1_exp    <= $signed({2'b00, exp_a} + {2'b00, exp_b} - 10'd127);
      s1_mant_a <= {1'b1, frac_a};
      s1_mant_b <= {1'b1, frac_b};
      s1_cls    <= cls_d;
    end
  end

  // ---------------- stage 2: mantissa product ----------------
  logic               s2_sign;
  logic signed [9:0]  s2_exp;
  logic [47:0]        s2_prod;
  cls_e               s2_cls;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_sign <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
      s2_cls  <= CLS_ZERO;
    end else begin
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_prod <= s1_mant_a * s1_mant_b;
      s2_cls  <= s1_cls;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [22:0]       frac_n;
  logic              guard, rnd, sticky, round_up;
  logic signed [9:0] exp_n, exp_r;
  logic [23:0]       frac_r;
  logic [31:0]       result_d;

  always_comb begin
    if (s2_prod[47]) begin
      frac_n = s2_prod[46:24];
      guard  = s2_prod[23];
      rnd    = s2_prod[22];
      sticky = |s2_prod[21:0];
      exp_n  = s2_exp + 10'sd1;
    end else begin
      frac_n = s2_prod[45:23];
      guard  = s2_prod[22];
      rnd    = s2_prod[21];
      sticky = |s2_prod[20:0];
      exp_n  = s2_exp;
    end
    // Ties go to the even fraction: round up on an exact half only if LSB is 1.
    round_up = guard & (rnd | sticky | frac_n[0]);
    frac_r   = {1'b0, frac_n} + 24'(round_up);
    // A carry out of the fraction leaves frac_r[22:0] all zero: just bump exp.
    exp_r    = frac_r[23] ? exp_n + 10'sd1 : exp_n;

    result_d = {s2_sign, exp_r[7:0], frac_r[22:0]};
    case (s2_cls)
      CLS_NAN:  result_d = CANON_NAN;
      CLS_INF:  result_d = {s2_sign, 8'hFF, 23'h0};
      CLS_ZERO: result_d = {s2_sign, 31'h0};
      default: begin
        if (exp_r >= 10'sd255)    result_d = {s2_sign, 8'hFF, 23'h0};
        else if (exp_r <= 10'sd0) result_d = {s2_sign, 31'h0};
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) result <= '0;
    else       result <= result_d;
  end

endmodule

// File: tb/tb_fp_mult.sv
// Self-checking bench for fp_mult: directed special cases, boundaries, random
// operands against an integer-arithmetic reference model, and reset flushes.
module tb_fp_mult;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  // Expected results still in flight; an operand captured at edge n is due
  // on result after edge n+2 (three register stages, capture edge included).
  logic [31:0] pipe[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  fp_mult dut (
    .clock (clock),
    .reset (reset),
    .dataA (dataA),
    .dataB (dataB),
    .result(result)
  );

  always #5 clock = ~clock;

  // Reference: exact integer product, scaled to 24 significant bits with
  // round-half-to-even decided by comparing the discarded remainder to half.
  function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, k, sh, e;
    bit na, nb, ia, ib, za, zb;
    longint unsigned ma, mb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb) return 32'h7F800001;
    if ((ia && zb) || (ib && za)) return 32'h7F800001;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    p  = ma * mb;
    k  = (p >= (64'd1 << 47)) ? 47 : 46;
    sh = k - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      k = k + 1;
    end
    e = k + ea + eb - 173;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, 8'(e), q[22:0]};
  endfunction

  // Mixes zeros, denormals, infinities, NaNs and normals of varied range.
  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int sel;
    sel = int'($urandom_range(0, 9));
    f   = 23'($urandom);
    case (sel)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       begin e = 8'h00; f = '0; end
      3:       begin e = 8'hFF; f = '0; end
      4, 5:    e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(90, 164));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Drives one operand pair for one edge and advances the expected pipeline.
  task automatic cycle(input logic [31:0] a, input logic [31:0] b,
                       input logic rst, output logic [31:0] expv);
    dataA = a;
    dataB = b;
    reset = rst;
    @(posedge clock);
    #1;
    if (rst) begin
      pipe.delete();
      repeat (2) pipe.push_back(32'h0);
      expv = 32'h0;
    end else begin
      pipe.push_back(ref_mult(a, b));
      expv = pipe.pop_front();
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      cycle($urandom, $urandom, 1'b1, e);
      n_cmp++;
      if (result !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, result, 32'h0);
      end
    end
    // First operands after release must wait their full latency; zeros before.
    cycle(32'h41400000, 32'h41400000, 1'b0, e);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (result !== ((i == 2) ? 32'h43100000 : 32'h0)) begin
        n_err++;
        $display("FAIL post_reset edge%0d: got %h want %h", i, result,
                 (i == 2) ? 32'h43100000 : 32'h0);
      end
      if (i < 2) cycle(32'h0, 32'h0, 1'b0, e);
    end
  endtask

  task automatic test_directed();
    vec_t v[8];
    logic [31:0] e;
    v = '{'{32'h00000000, 32'h41400000, 32'h00000000},
          '{32'h80000000, 32'h41400000, 32'h80000000},
          '{32'h7F800000, 32'h41400000, 32'h7F800000},
          '{32'hFF800000, 32'h41400000, 32'hFF800000},
          '{32'h7F800000, 32'h00000000, 32'h7F800001},
          '{32'h7F800001, 32'h41400000, 32'h7F800001},
          '{32'h41400000, 32'h41400000, 32'h43100000},
          '{32'h3FC00000, 32'hC0000000, 32'hC0400000}};
    for (int i = 0; i < 8; i++) begin
      cycle(v[i].a, v[i].b, 1'b0, e);
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (result !== e) begin
          n_err++;
          $display("FAIL directed_lat v%0d e%0d: got %h want %h", i, j, result, e);
        end
        cycle(32'h0, 32'h0, 1'b0, e);
      end
      n_cmp++;
      if (result !== v[i].y) begin
        n_err++;
        $display("FAIL directed v%0d %h*%h: got %h want %h", i, v[i].a, v[i].b, result, v[i].y);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[5];
    logic [31:0] e;
    v = '{'{32'h00000000, 32'h41400000, 32'h00000000},
          '{32'h7F800000, 32'h41400000, 32'h7F800000},
          '{32'h7F800000, 32'h00000000, 32'h7F800001},
          '{32'h7F800001, 32'h41400000, 32'h7F800001},
          '{32'h41400000, 32'h41400000, 32'h43100000}};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) cycle(v[i].a, v[i].b, 1'b0, e);
      else       cycle(32'h0, 32'h0, 1'b0, e);
      if (i >= 2) begin
        n_cmp++;
        if (result !== v[i-2].y) begin
          n_err++;
          $display("FAIL b2b op%0d: got %h want %h", i - 2, result, v[i-2].y);
        end
      end
    end
  endtask

  task automatic test_boundary();
    vec_t v[9];
    logic [31:0] e;
    v = '{'{32'h7F000000, 32'h7F000000, 32'h7F800000},  // overflow
          '{32'h00800000, 32'h00800000, 32'h00000000},  // underflow
          '{32'h3F800000, 32'h00800000, 32'h00800000},  // smallest normal kept
          '{32'h3F800001, 32'h3FC00000, 32'h3FC00002},  // tie, odd -> up
          '{32'h3F800003, 32'h3FC00000, 32'h3FC00004},  // tie, even -> stay
          '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000},  // rounding carry-out
          '{32'h3F800001, 32'h7F7FFFFE, 32'h7F800000},  // overflow after round
          '{32'h80400000, 32'h41400000, 32'h80000000},  // denormal flushed
          '{32'h7F800000, 32'h00000001, 32'h7F800001}}; // inf * denormal
    for (int i = 0; i < 9; i++) begin
      cycle(v[i].a, v[i].b, 1'b0, e);
      cycle(32'h0, 32'h0, 1'b0, e);
      cycle(32'h0, 32'h0, 1'b0, e);
      n_cmp++;
      if (result !== v[i].y) begin
        n_err++;
        $display("FAIL boundary v%0d %h*%h: got %h want %h", i, v[i].a, v[i].b, result, v[i].y);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e, a, b;
    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      b = rand_op();
      cycle(a, b, 1'b0, e);
      n_cmp++;
      if (result !== e) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h want %h", i, result, e);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] e;
    for (int i = 0; i < 6; i++) cycle(32'h3FC00000, rand_op(), 1'b0, e);
    cycle(32'h41400000, 32'h41400000, 1'b1, e);
    n_cmp++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL flush_rst: got %h want %h", result, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(32'h41400000, 32'h3FC00000, 1'b0, e);
      n_cmp++;
      if (result !== e) begin
        n_err++;
        $display("FAIL flush_after cyc%0d: got %h want %h", i, result, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    dataA = '0;
    dataB = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_boundary();
    test_random();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
